// File: rtl/tetris_playfield.sv
// tetris_playfield
// Settled-cell store for a Tetris playfield plus its line-clear engine.
// A locked 4x4 piece is merged into the board through a valid/ready
// handshake. The rows are then scanned from the bottom up, one row per
// cycle, and every full row is removed by shifting the rows above it down.
//
// Ports
//   CLK, RESET      single clock, synchronous active-high reset
//   add_valid       lock request; add_ready is high while the block is IDLE
//   block_arr       4x4 piece mask, column-major: bit i -> (x_coord+i/4, y_coord+i%4)
//   x_coord/y_coord top-left corner of the 4x4 box (row 0 is the top row)
//   block_color     colour written to each set mask cell (0 means empty)
//   clear_all       wipes the board; only honoured while IDLE
//   board_arr       packed board, cell (x,y) at [(x*ROWS+y)*CBITS +: CBITS]
//   busy            high whenever the block is not IDLE
//   done            one-cycle pulse when a lock and its clear are complete
//   lines_cleared   rows removed by the most recent lock
//   lines_total     cumulative removed rows, saturating at 16'hFFFF
//   lock_err        a mask cell fell off the board or overlapped a settled cell
module tetris_playfield #(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int CBITS = 3,
    parameter int XW    = $clog2(COLS),
    parameter int YW    = $clog2(ROWS)
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        add_valid,
    output logic                        add_ready,
    input  logic [15:0]                 block_arr,
    input  logic [XW-1:0]               x_coord,
    input  logic [YW-1:0]               y_coord,
    input  logic [CBITS-1:0]            block_color,
    input  logic                        clear_all,
    output logic [COLS*ROWS*CBITS-1:0]  board_arr,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  lines_cleared,
    output logic [15:0]                 lines_total,
    output logic                        lock_err
);

    typedef enum logic [1:0] {IDLE, LOCK, SCAN, DONE} state_t;

    state_t             state;
    logic [CBITS-1:0]   board [COLS][ROWS];

    logic [15:0]        mask_q;
    logic [XW-1:0]      x_q;
    logic [YW-1:0]      y_q;
    logic [CBITS-1:0]   color_q;
    logic [YW-1:0]      row_ptr;

    logic [XW:0]        cell_x [16];
    logic [YW:0]        cell_y [16];
    logic [15:0]        cell_in;
    logic               lock_fault;
    logic               row_full;
    logic [16:0]        total_sum;

    assign add_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Target coordinates of every mask cell, computed one bit wider than the
    // board coordinates so that cells hanging off the right or bottom edge
    // are detected instead of wrapping into another column or row.
    always_comb begin
        lock_fault = 1'b0;
        cell_in    = '0;
        for (int i = 0; i < 16; i++) begin
            cell_x[i]  = {1'b0, x_q} + (XW+1)'(i / 4);
            cell_y[i]  = {1'b0, y_q} + (YW+1)'(i % 4);
            cell_in[i] = (cell_x[i] < (XW+1)'(COLS)) && (cell_y[i] < (YW+1)'(ROWS));
            if (mask_q[i]) begin
                if (!cell_in[i]) begin
                    lock_fault = 1'b1;
                end else if (board[cell_x[i][XW-1:0]][cell_y[i][YW-1:0]] != '0) begin
                    lock_fault = 1'b1;
                end
            end
        end
    end

    // A row is full when no cell in it is empty.
    always_comb begin
        row_full = 1'b1;
        for (int x = 0; x < COLS; x++) begin
            if (board[x][row_ptr] == '0) begin
                row_full = 1'b0;
            end
        end
    end

    // Wide sum so the cumulative count can saturate rather than wrap.
    always_comb begin
        total_sum = {1'b0, lines_total} + 17'(lines_cleared);
    end

    // Flatten the board for the renderer.
    always_comb begin
        board_arr = '0;
        for (int x = 0; x < COLS; x++) begin
            for (int y = 0; y < ROWS; y++) begin
                board_arr[(x*ROWS+y)*CBITS +: CBITS] = board[x][y];
            end
        end
    end

    // Control FSM and board storage. A full row keeps row_ptr where it is so
    // that the row shifted down into that position is checked as well.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            done          <= 1'b0;
            lines_cleared <= '0;
            lines_total   <= '0;
            lock_err      <= 1'b0;
            row_ptr       <= '0;
            mask_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            color_q       <= '0;
            for (int x = 0; x < COLS; x++) begin
                for (int y = 0; y < ROWS; y++) begin
                    board[x][y] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (add_valid) begin
                        mask_q        <= block_arr;
                        x_q           <= x_coord;
                        y_q           <= y_coord;
                        color_q       <= block_color;
                        lock_err      <= 1'b0;
                        lines_cleared <= '0;
                        state         <= LOCK;
                    end else if (clear_all) begin
                        for (int x = 0; x < COLS; x++) begin
                            for (int y = 0; y < ROWS; y++) begin
                                board[x][y] <= '0;
                            end
                        end
                    end
                end
                LOCK: begin
                    for (int i = 0; i < 16; i++) begin
                        if (mask_q[i] && cell_in[i]) begin
                            board[cell_x[i][XW-1:0]][cell_y[i][YW-1:0]] <= color_q;
                        end
                    end
                    lock_err <= lock_fault;
                    row_ptr  <= YW'(ROWS - 1);
                    state    <= SCAN;
                end
                SCAN: begin
                    if (row_full) begin
                        for (int x = 0; x < COLS; x++) begin
                            board[x][0] <= '0;
                            for (int y = 1; y < ROWS; y++) begin
                                if (y <= int'(row_ptr)) begin
                                    board[x][y] <= board[x][y-1];
                                end
                            end
                        end
                        lines_cleared <= lines_cleared + 3'd1;
                    end else if (row_ptr == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        row_ptr <= row_ptr - 1'b1;
                    end
                end
                DONE: begin
                    lines_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
